// File: rtl/parking_gate_controller.sv
// Entry/exit sequencer for an 8-spot lot: keeps the occupancy bitmap, assigns the lowest free spot, runs the gate.
// Optional gate auto-close timeout is compiled in with `define PARKING_GATE_TIMEOUT_EN.
module parking_gate_controller #(
  parameter int unsigned GATE_HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry,
  input  logic       exit_req,
  input  logic [2:0] exit_spot,
  input  logic       car_passed,
  output logic [7:0] parking_capacity,
  output logic [2:0] park_number,
  output logic       park_valid,
  output logic       entry_deny,
  output logic       exit_err,
  output logic       gate_open,
  output logic [3:0] free_count,
`ifdef PARKING_GATE_TIMEOUT_EN
  output logic       busy,
  output logic       timeout
`else
  output logic       busy
`endif
);

  typedef enum logic [1:0] {IDLE, ENTRY_OPEN, EXIT_OPEN, CLOSE} state_t;

  if (GATE_HOLD_CYCLES < 2 || GATE_HOLD_CYCLES > 255) begin : g_bad_hold
    $error("GATE_HOLD_CYCLES must be in 2..255");
  end

  state_t     state_q, state_d;
  logic [7:0] cap_d;
  logic [2:0] num_d;
  logic [2:0] exit_q, exit_d;
  logic       valid_d, deny_d, err_d;
  logic [2:0] lowest_free;

`ifdef PARKING_GATE_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(GATE_HOLD_CYCLES - 1);
  logic [7:0] hold_q, hold_d;
  logic       timeout_d;
`endif

  always_comb begin
    lowest_free = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (!parking_capacity[i-1]) lowest_free = 3'(i - 1);
    end
  end

  always_comb begin
    free_count = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      free_count = free_count + {3'b000, ~parking_capacity[i]};
    end
  end

  assign gate_open = (state_q == ENTRY_OPEN) || (state_q == EXIT_OPEN);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cap_d   = parking_capacity;
    num_d   = park_number;
    exit_d  = exit_q;
    valid_d = 1'b0;
    deny_d  = 1'b0;
    err_d   = 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef PARKING_GATE_TIMEOUT_EN
        hold_d = '0;
`endif
        // exit first: it can only free a spot, never consume one
        if (exit_req) begin
          if (parking_capacity[exit_spot]) begin
            state_d = EXIT_OPEN;
            exit_d  = exit_spot;
          end else begin
            err_d = 1'b1;
          end
        end else if (entry) begin
          if (free_count != 4'd0) begin
            state_d = ENTRY_OPEN;
            num_d   = lowest_free;
            valid_d = 1'b1;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        if (car_passed) begin
          if (state_q == ENTRY_OPEN) cap_d[park_number] = 1'b1;
          else                       cap_d[exit_q]      = 1'b0;
          state_d = CLOSE;
        end
`ifdef PARKING_GATE_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          timeout_d = 1'b1;
          state_d   = CLOSE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      parking_capacity <= '0;
      park_number      <= '0;
      exit_q           <= '0;
      park_valid       <= 1'b0;
      entry_deny       <= 1'b0;
      exit_err         <= 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
      hold_q           <= '0;
      timeout          <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      parking_capacity <= cap_d;
      park_number      <= num_d;
      exit_q           <= exit_d;
      park_valid       <= valid_d;
      entry_deny       <= deny_d;
      exit_err         <= err_d;
`ifdef PARKING_GATE_TIMEOUT_EN
      hold_q           <= hold_d;
      timeout          <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: directed vector table, corner sequences, and random transactions vs an occupancy model.
// Exercises the timeout path when PARKING_GATE_TIMEOUT_EN is defined.
module tb_parking_gate_controller;

  logic       clk = 1'b0;
  logic       rst_n, entry, exit_req, car_passed;
  logic [2:0] exit_spot;
  logic [7:0] parking_capacity;
  logic [2:0] park_number;
  logic       park_valid, entry_deny, exit_err, gate_open, busy;
  logic [3:0] free_count;
`ifdef PARKING_GATE_TIMEOUT_EN
  logic       timeout;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  parking_gate_controller #(.GATE_HOLD_CYCLES(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .entry            (entry),
    .exit_req         (exit_req),
    .exit_spot        (exit_spot),
    .car_passed       (car_passed),
    .parking_capacity (parking_capacity),
    .park_number      (park_number),
    .park_valid       (park_valid),
    .entry_deny       (entry_deny),
    .exit_err         (exit_err),
    .gate_open        (gate_open),
    .free_count       (free_count),
    .busy             (busy)
`ifdef PARKING_GATE_TIMEOUT_EN
    , .timeout        (timeout)
`endif
  );

  typedef struct {
    bit          e;
    bit          x;
    logic [2:0]  s;
    int unsigned hold;
    bit          ev;
    logic [2:0]  en;
    bit          ed;
    bit          ee;
    logic [7:0]  cap;
  } vec_t;

  vec_t tbl[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] zeros(input logic [7:0] m);
    int n = 0;
    for (int i = 0; i < 8; i++) if (m[i] == 1'b0) n++;
    return 4'(n);
  endfunction

  // one request held for a single cycle; if the gate opens, car passes after `hold` idle cycles
  task automatic do_txn(input bit e, input bit x, input logic [2:0] s, input int unsigned hold,
                        input bit ev, input logic [2:0] en, input bit ed, input bit ee,
                        input logic [7:0] ecap);
    bit eo;
    eo = ev | (x & ~ee);
    entry = e; exit_req = x; exit_spot = s;
    tick();
    entry = 1'b0; exit_req = 1'b0;
    chk("park_valid", park_valid, ev);
    chk("entry_deny", entry_deny, ed);
    chk("exit_err", exit_err, ee);
    chk("gate_open_grant", gate_open, eo);
    chk("busy_grant", busy, eo);
    if (ev) chk("park_number", park_number, en);
    if (eo) begin
      repeat (hold) tick();
      chk("gate_held", gate_open, 1'b1);
      car_passed = 1'b1;
      tick();
      car_passed = 1'b0;
      chk("gate_closed", gate_open, 1'b0);
      chk("busy_close", busy, 1'b1);
    end
    chk("capacity", parking_capacity, ecap);
    chk("free_count", free_count, zeros(ecap));
    tick();
    chk("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit [7:0]    occ;
    bit          e, x, ev, ed, ee;
    logic [2:0]  s, en;
    int unsigned r;

    tbl[0]  = '{1'b1, 1'b0, 3'd0, 0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h01};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 1, 1'b1, 3'd1, 1'b0, 1'b0, 8'h03};
    tbl[2]  = '{1'b1, 1'b0, 3'd0, 2, 1'b1, 3'd2, 1'b0, 1'b0, 8'h07};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 3, 1'b1, 3'd3, 1'b0, 1'b0, 8'h0F};
    tbl[4]  = '{1'b1, 1'b0, 3'd0, 0, 1'b1, 3'd4, 1'b0, 1'b0, 8'h1F};
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h3F};
    tbl[6]  = '{1'b1, 1'b0, 3'd0, 0, 1'b1, 3'd6, 1'b0, 1'b0, 8'h7F};
    tbl[7]  = '{1'b1, 1'b0, 3'd0, 2, 1'b1, 3'd7, 1'b0, 1'b0, 8'hFF};
    tbl[8]  = '{1'b1, 1'b0, 3'd0, 0, 1'b0, 3'd0, 1'b1, 1'b0, 8'hFF};
    tbl[9]  = '{1'b0, 1'b1, 3'd3, 0, 1'b0, 3'd0, 1'b0, 1'b0, 8'hF7};
    tbl[10] = '{1'b0, 1'b1, 3'd4, 1, 1'b0, 3'd0, 1'b0, 1'b0, 8'hE7};
    tbl[11] = '{1'b0, 1'b1, 3'd6, 3, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA7};
    tbl[12] = '{1'b1, 1'b0, 3'd0, 0, 1'b1, 3'd3, 1'b0, 1'b0, 8'hAF};
    tbl[13] = '{1'b0, 1'b1, 3'd4, 0, 1'b0, 3'd0, 1'b0, 1'b1, 8'hAF};
    tbl[14] = '{1'b0, 1'b1, 3'd3, 0, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA7};
    tbl[15] = '{1'b1, 1'b0, 3'd0, 1, 1'b1, 3'd3, 1'b0, 1'b0, 8'hAF};
    tbl[16] = '{1'b1, 1'b0, 3'd0, 0, 1'b1, 3'd4, 1'b0, 1'b0, 8'hBF};
    tbl[17] = '{1'b1, 1'b1, 3'd6, 0, 1'b0, 3'd0, 1'b0, 1'b1, 8'hBF};

    rst_n = 1'b0; entry = 1'b0; exit_req = 1'b0; exit_spot = '0; car_passed = 1'b0;
    tick(); tick();
    chk("rst_capacity", parking_capacity, 8'h00);
    chk("rst_free", free_count, 4'd8);
    chk("rst_number", park_number, 3'd0);
    chk("rst_gate", gate_open, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulses", {park_valid, entry_deny, exit_err}, 3'b000);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++)
      do_txn(tbl[i].e, tbl[i].x, tbl[i].s, tbl[i].hold,
             tbl[i].ev, tbl[i].en, tbl[i].ed, tbl[i].ee, tbl[i].cap);

    // car_passed while idle must not touch the bitmap
    car_passed = 1'b1; tick(); car_passed = 1'b0; tick();
    chk("idle_pass_cap", parking_capacity, 8'hBF);

    // exit of spot 5 wins over a held entry, which then takes spot 5
    entry = 1'b1; exit_req = 1'b1; exit_spot = 3'd5;
    tick();
    exit_req = 1'b0;
    chk("sim_gate", gate_open, 1'b1);
    chk("sim_no_valid", park_valid, 1'b0);
    car_passed = 1'b1; tick(); car_passed = 1'b0;
    chk("sim_exit_cap", parking_capacity, 8'h9F);
    chk("sim_close_valid", park_valid, 1'b0);
    tick();
    chk("sim_idle_valid", park_valid, 1'b0);
    tick();
    entry = 1'b0;
    chk("sim_entry_valid", park_valid, 1'b1);
    chk("sim_entry_num", park_number, 3'd5);
    car_passed = 1'b1; tick(); car_passed = 1'b0;
    chk("sim_entry_cap", parking_capacity, 8'hBF);
    tick();

`ifdef PARKING_GATE_TIMEOUT_EN
    entry = 1'b1; tick(); entry = 1'b0;
    chk("to_valid", park_valid, 1'b1);
    chk("to_num", park_number, 3'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_gate_wait", gate_open, 1'b1);
      chk("to_early", timeout, 1'b0);
    end
    tick();
    chk("to_pulse", timeout, 1'b1);
    chk("to_gate", gate_open, 1'b0);
    chk("to_cap", parking_capacity, 8'hBF);
    tick();
    chk("to_pulse_end", timeout, 1'b0);
    chk("to_busy", busy, 1'b0);
    do_txn(1'b1, 1'b0, 3'd0, 3, 1'b1, 3'd6, 1'b0, 1'b0, 8'hFF);
`else
    do_txn(1'b1, 1'b0, 3'd0, 20, 1'b1, 3'd6, 1'b0, 1'b0, 8'hFF);
`endif

    do_txn(1'b0, 1'b1, 3'd0, 0, 1'b0, 3'd0, 1'b0, 1'b0, 8'hFE);
    entry = 1'b1; tick(); entry = 1'b0;
    chk("mid_gate", gate_open, 1'b1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst_gate", gate_open, 1'b0);
    chk("mid_rst_cap", parking_capacity, 8'h00);
    chk("mid_rst_free", free_count, 4'd8);
    chk("mid_rst_busy", busy, 1'b0);
    tick();

    occ = '0;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      e = (r < 45) || (r >= 80);
      x = (r >= 45);
      s = 3'($urandom_range(0, 7));
      ev = 1'b0; ed = 1'b0; ee = 1'b0; en = '0;
      if (x) begin
        if (occ[s]) occ[s] = 1'b0;
        else        ee = 1'b1;
      end else if (occ != 8'hFF) begin
        ev = 1'b1;
        for (int i = 7; i >= 0; i--) if (!occ[i]) en = 3'(i);
        occ[en] = 1'b1;
      end else begin
        ed = 1'b1;
      end
      do_txn(e, x, s, $urandom_range(0, 3), ev, en, ed, ee, occ);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
